// File: rtl/write_back_stage.sv
// Writeback end of the register-file interface: a two-entry in-order queue of
// completed results (ALU now, loads later) that drives the register-file write port.
module write_back_stage #(
    parameter int          DEPTH    = 2,
    parameter logic [4:0]  ZERO_REG = 5'd31
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        exValid,
    output logic        exReady,
    input  logic [4:0]  exDest,
    input  logic [31:0] exData,
    input  logic        exIsLoad,
    input  logic        memValid,
    input  logic [31:0] memData,
    input  logic [4:0]  reg1,
    input  logic [4:0]  reg2,
    output logic        stall,
    output logic        regWrite,
    output logic [4:0]  writeRegister,
    output logic [31:0] writeData,
    output logic        memError
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    logic [4:0]  dest_q [2];
    logic [4:0]  dest_d [2];
    logic [31:0] data_q [2];
    logic [31:0] data_d [2];
    logic [1:0]  valid_q, valid_d;
    logic [1:0]  isLoad_q, isLoad_d;
    logic [1:0]  filled_q, filled_d;
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic        regWrite_q, regWrite_d;
    logic [4:0]  writeRegister_q, writeRegister_d;
    logic [31:0] writeData_q, writeData_d;
    logic        memError_q, memError_d;

    logic        pushEn;
    logic        popEn;
    logic        fillHit;
    logic        fillIdx;
    logic        stall1;
    logic        stall2;

    assign exReady       = (count_q < FULL_COUNT);
    assign regWrite      = regWrite_q;
    assign writeRegister = writeRegister_q;
    assign writeData     = writeData_q;
    assign memError      = memError_q;

    // A source register stalls if any queued write or the write being strobed targets it.
    always_comb begin
        stall1 = 1'b0;
        stall2 = 1'b0;
        if (reg1 != ZERO_REG) begin
            stall1 = (valid_q[0] && dest_q[0] == reg1) ||
                     (valid_q[1] && dest_q[1] == reg1) ||
                     (regWrite_q && writeRegister_q == reg1);
        end
        if (reg2 != ZERO_REG) begin
            stall2 = (valid_q[0] && dest_q[0] == reg2) ||
                     (valid_q[1] && dest_q[1] == reg2) ||
                     (regWrite_q && writeRegister_q == reg2);
        end
        stall = stall1 || stall2;
    end

    // Push, fill and retire all look at the queue as it stood at the start of the cycle.
    always_comb begin
        dest_d          = dest_q;
        data_d          = data_q;
        valid_d         = valid_q;
        isLoad_d        = isLoad_q;
        filled_d        = filled_q;
        head_d          = head_q;
        tail_d          = tail_q;
        regWrite_d      = 1'b0;
        writeRegister_d = writeRegister_q;
        writeData_d     = writeData_q;
        memError_d      = memError_q;

        pushEn = exValid && exReady;
        popEn  = valid_q[head_q] && filled_q[head_q];

        fillHit = 1'b0;
        fillIdx = head_q;
        if (valid_q[head_q] && isLoad_q[head_q] && !filled_q[head_q]) begin
            fillHit = 1'b1;
            fillIdx = head_q;
        end else if (valid_q[~head_q] && isLoad_q[~head_q] && !filled_q[~head_q]) begin
            fillHit = 1'b1;
            fillIdx = ~head_q;
        end

        if (memValid) begin
            if (fillHit) begin
                data_d[fillIdx]   = memData;
                filled_d[fillIdx] = 1'b1;
            end else begin
                memError_d = 1'b1;
            end
        end

        if (popEn) begin
            valid_d[head_q] = 1'b0;
            head_d          = ~head_q;
            regWrite_d      = (dest_q[head_q] != ZERO_REG);
            writeRegister_d = dest_q[head_q];
            writeData_d     = data_q[head_q];
        end

        if (pushEn) begin
            valid_d[tail_q]  = 1'b1;
            dest_d[tail_q]   = exDest;
            data_d[tail_q]   = exIsLoad ? 32'd0 : exData;
            isLoad_d[tail_q] = exIsLoad;
            filled_d[tail_q] = !exIsLoad;
            tail_d           = ~tail_q;
        end

        count_d = count_q + {1'b0, pushEn} - {1'b0, popEn};
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            dest_q          <= '{default: 5'd0};
            data_q          <= '{default: 32'd0};
            valid_q         <= 2'b00;
            isLoad_q        <= 2'b00;
            filled_q        <= 2'b00;
            head_q          <= 1'b0;
            tail_q          <= 1'b0;
            count_q         <= 2'd0;
            regWrite_q      <= 1'b0;
            writeRegister_q <= 5'd0;
            writeData_q     <= 32'd0;
            memError_q      <= 1'b0;
        end else begin
            dest_q          <= dest_d;
            data_q          <= data_d;
            valid_q         <= valid_d;
            isLoad_q        <= isLoad_d;
            filled_q        <= filled_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            regWrite_q      <= regWrite_d;
            writeRegister_q <= writeRegister_d;
            writeData_q     <= writeData_d;
            memError_q      <= memError_d;
        end
    end

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_write_back_stage;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        bit          isLoad;
        bit          filled;
    } entry_t;

    logic        clock = 1'b0;
    logic        resetN;
    logic        exValid;
    logic        exReady;
    logic [4:0]  exDest;
    logic [31:0] exData;
    logic        exIsLoad;
    logic        memValid;
    logic [31:0] memData;
    logic [4:0]  reg1;
    logic [4:0]  reg2;
    logic        stall;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        memError;

    entry_t      mq[$];
    logic        mRegWrite;
    logic [4:0]  mWriteReg;
    logic [31:0] mWriteData;
    logic        mMemError;

    int errCount   = 0;
    int checkCount = 0;

    always #5 clock = ~clock;

    write_back_stage #(.DEPTH(2), .ZERO_REG(5'd31)) dut (
        .clock(clock), .resetN(resetN),
        .exValid(exValid), .exReady(exReady), .exDest(exDest), .exData(exData), .exIsLoad(exIsLoad),
        .memValid(memValid), .memData(memData),
        .reg1(reg1), .reg2(reg2), .stall(stall),
        .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
        .memError(memError)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic bit modelStall(input logic [4:0] r);
        bit hit = 0;
        if (r == 5'd31) return 0;
        foreach (mq[i]) if (mq[i].dest == r) hit = 1;
        if (mRegWrite && mWriteReg == r) hit = 1;
        return hit;
    endfunction

    task automatic applyStimulus(input logic v, input logic isLoad, input logic [4:0] dest,
                                 input logic [31:0] data, input logic mv, input logic [31:0] md,
                                 input logic [4:0] r1, input logic [4:0] r2);
        exValid  = v;
        exIsLoad = isLoad;
        exDest   = dest;
        exData   = data;
        memValid = mv;
        memData  = md;
        reg1     = r1;
        reg2     = r2;
    endtask

    // One clock: check combinational outputs, advance the model, then check registered outputs.
    task automatic stepCycle();
        entry_t e;
        entry_t head;
        bit     ready;
        bit     canPop;
        int     fillIdx;
        #1;
        checkOutput("exReady", exReady, (mq.size() < 2));
        checkOutput("stall", stall, modelStall(reg1) || modelStall(reg2));
        if (!resetN) begin
            mq.delete();
            mRegWrite  = 0;
            mWriteReg  = 0;
            mWriteData = 0;
            mMemError  = 0;
        end else begin
            ready   = (mq.size() < 2);
            canPop  = (mq.size() > 0) && mq[0].filled;
            fillIdx = -1;
            foreach (mq[i]) if (fillIdx < 0 && mq[i].isLoad && !mq[i].filled) fillIdx = i;
            if (memValid) begin
                if (fillIdx >= 0) begin
                    e = mq[fillIdx];
                    e.data = memData;
                    e.filled = 1;
                    mq[fillIdx] = e;
                end else begin
                    mMemError = 1;
                end
            end
            if (canPop) begin
                head       = mq.pop_front();
                mRegWrite  = (head.dest != 5'd31);
                mWriteReg  = head.dest;
                mWriteData = head.data;
            end else begin
                mRegWrite = 0;
            end
            if (exValid && ready) begin
                e.dest   = exDest;
                e.isLoad = exIsLoad;
                e.data   = exIsLoad ? 32'd0 : exData;
                e.filled = !exIsLoad;
                mq.push_back(e);
            end
        end
        @(posedge clock);
        #1;
        checkOutput("regWrite", regWrite, mRegWrite);
        checkOutput("writeRegister", writeRegister, mWriteReg);
        checkOutput("writeData", writeData, mWriteData);
        checkOutput("memError", memError, mMemError);
    endtask

    task automatic idle(input int n, input logic [4:0] r1);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, r1, 0);
            stepCycle();
        end
    endtask

    initial begin
        resetN = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        mq.delete();
        mRegWrite = 0; mWriteReg = 0; mWriteData = 0; mMemError = 0;
        checkOutput("rstRegWrite", regWrite, 0);
        checkOutput("rstWriteReg", writeRegister, 0);
        checkOutput("rstWriteData", writeData, 0);
        checkOutput("rstMemError", memError, 0);
        checkOutput("rstExReady", exReady, 1);
        checkOutput("rstStall", stall, 0);
        resetN = 1'b1;

        // ALU result: strobe appears exactly two edges after accept, for one cycle
        applyStimulus(1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        stepCycle();
        idle(1, 0);
        checkOutput("aluStrobe", regWrite, 1);
        checkOutput("aluReg", writeRegister, 5);
        checkOutput("aluData", writeData, 32'hDEADBEEF);
        idle(1, 0);
        checkOutput("aluPulse", regWrite, 0);

        // Load followed by ALU: ALU waits behind the unfilled load
        applyStimulus(1, 1, 3, 32'h55, 0, 0, 0, 0);
        stepCycle();
        applyStimulus(1, 0, 4, 32'h11, 0, 0, 0, 0);
        stepCycle();
        idle(3, 0);
        checkOutput("loadWait", regWrite, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h22, 0, 0);
        stepCycle();
        idle(1, 0);
        checkOutput("loadReg", writeRegister, 3);
        checkOutput("loadData", writeData, 32'h22);
        idle(1, 0);
        checkOutput("aluAfterLoad", writeData, 32'h11);
        idle(2, 0);

        // Two loads fill the queue; reg1 matches the younger load
        applyStimulus(1, 1, 7, 0, 0, 0, 8, 0);
        stepCycle();
        applyStimulus(1, 1, 8, 0, 0, 0, 8, 0);
        stepCycle();
        applyStimulus(1, 0, 9, 32'h99, 0, 0, 8, 0);
        #1;
        checkOutput("fullReady", exReady, 0);
        checkOutput("fullStall", stall, 1);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 1, 32'h70, 8, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 1, 32'h80, 8, 0);
        stepCycle();
        idle(4, 8);
        checkOutput("stallClear", stall, 0);

        // ZERO_REG write is dropped and never stalls
        applyStimulus(1, 0, 31, 32'h1234, 0, 0, 31, 31);
        stepCycle();
        idle(3, 31);

        // Stray memory return sets the sticky error
        applyStimulus(0, 0, 0, 0, 1, 32'hBAD, 0, 0);
        stepCycle();
        idle(3, 0);
        checkOutput("memErrSticky", memError, 1);

        // Mid-operation reset discards a pending load
        resetN = 1'b0;
        idle(1, 0);
        resetN = 1'b1;
        applyStimulus(1, 1, 12, 0, 0, 0, 0, 0);
        stepCycle();
        idle(1, 0);
        resetN = 1'b0;
        idle(1, 0);
        resetN = 1'b1;
        checkOutput("midRstReady", exReady, 1);
        applyStimulus(0, 0, 0, 0, 1, 32'h77, 12, 0);
        stepCycle();
        idle(1, 0);
        checkOutput("midRstErr", memError, 1);
        checkOutput("midRstNoWrite", regWrite, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            resetN = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
            applyStimulus($urandom_range(99) < 60, $urandom_range(99) < 40,
                          5'($urandom_range(31)), $urandom,
                          $urandom_range(99) < 30, $urandom,
                          5'($urandom_range(31)), 5'($urandom_range(31)));
            stepCycle();
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/write_back_stage.md
# write_back_stage

Writeback end of the register-file interface. Accepts completed results from execute (ALU results immediately, loads with variable-latency memory data), holds up to two in-order pending writes, and drives the register-file write port (`regWrite`/`writeRegister`/`writeData`) consumed by the operand-preparation stage. It also raises a read-after-write stall toward operand preparation when a requested source register has a write still in flight.

## Interface
Parameters:
- `DEPTH`, 2, pending-write queue entries; the only supported value is 2.
- `ZERO_REG`, 31, register address whose writes are dropped (XZR).

Ports:
- `clock`  in  1  main clock; all state updates on posedge.
- `resetN`  in  1  synchronous, active-low reset.
- `exValid`  in  1  execute presents a result.
- `exReady`  out  1  queue can accept; combinational, `count < 2`.
- `exDest`  in  5  destination register.
- `exData`  in  32  ALU result; ignored when `exIsLoad`=1.
- `exIsLoad`  in  1  result data arrives later on `memValid`/`memData`.
- `memValid`  in  1  load data returned; in order.
- `memData`  in  32  load data.
- `reg1`, `reg2`  in  5 each  operand-prep source addresses.
- `stall`  out  1  combinational RAW hazard flag.
- `regWrite`  out  1  registered write strobe to the register file.
- `writeRegister`  out  5  registered write address.
- `writeData`  out  32  registered write data.
- `memError`  out  1  sticky: `memValid` seen with no unfilled load pending.

## Operation
- Queue: 2-entry in-order FIFO.
  - Each entry holds {dest, data, isLoad, filled}.
  - `count` ranges 0..2. Head and tail pointers are 1 bit and wrap 1→0.
- Accept: on `exValid && exReady`, push at the tail.
  - ALU result: `filled`=1, data=`exData`.
  - Load: `filled`=0, data=0.
- Fill: on `memValid`, write `memData` into the oldest entry with `isLoad`=1 and `filled`=0, then set its `filled`.
  - Only entries already present at the start of the cycle are fill candidates.
  - A load pushed in the same cycle is not a candidate.
  - If no candidate exists, set `memError`. The data is discarded.
- Retire, evaluated every cycle on the head as it stood at the start of the cycle:
  - Head valid and `filled`: pop it; next cycle `regWrite` = (dest != ZERO_REG), `writeRegister` = dest, `writeData` = data.
  - Otherwise: `regWrite` = 0; `writeRegister` and `writeData` hold their previous values.
- Simultaneous push and pop: allowed. `count` is unchanged and the pointers advance independently.
- Push when full: `exReady`=0, so no push occurs. A pop in the same cycle does not enable the push.
- Stall: `stall`=1 when `reg1` or `reg2` (either one, nonzero-reg only) matches either of:
  - the dest of any valid queue entry, or
  - `writeRegister` while `regWrite`=1.
  - Addresses equal to ZERO_REG never stall.
- Reset (`resetN`=0 at posedge):
  - `count`=0, pointers=0, all entries invalid.
  - `regWrite`=0, `writeRegister`=0, `writeData`=0, `memError`=0.
  - Reset overrides any simultaneous push, fill or pop. Pending loads are discarded.
  - A `memValid` in the first cycle after reset sets `memError`.

## Timing
- ALU result into an empty queue, accepted at edge N: popped at edge N+1; `regWrite`=1 during the cycle after edge N+1. Accept-to-strobe latency is 2 edges.
- Load fill at edge M, with the load at head: popped at edge M+1; `regWrite`=1 in the following cycle.
- Throughput: one retire per cycle. Back-to-back ALU results sustain `regWrite`=1 continuously.
- `regWrite` is high for exactly one cycle per retired non-ZERO_REG entry.
- In-order retire: a filled ALU entry behind an unfilled load waits. No bypass.
- `exReady` and `stall` are combinational from current state and inputs. All other outputs are registered.

## Test plan
- Reset then idle: hold `resetN`=0 for 2 cycles. Then `regWrite`=0, `writeRegister`=0, `writeData`=0, `memError`=0, `exReady`=1, `stall`=0.
- ALU writeback: push dest=5, data=0xDEADBEEF. `regWrite`=1 with `writeRegister`=5 and `writeData`=0xDEADBEEF exactly 2 edges after accept, for one cycle.
- Load ordering:
  - Stimulus: push load dest=3, then ALU dest=4 data=0x11. After 3 idle cycles, `memValid` with `memData`=0x22.
  - Required: no `regWrite` before the fill; then write reg3=0x22, then reg4=0x11 on consecutive cycles.
- Full and stall:
  - Stimulus: push two loads (dest=7, dest=8); drive `reg1`=8.
  - Required: `exReady`=0 and `stall`=1. After both fills and both retires, `stall`=0 once `regWrite` for reg8 has dropped.
- ZERO_REG and error:
  - Push ALU dest=31: no `regWrite` pulse and no stall for `reg1`=31.
  - `memValid` with the queue empty: `memError`=1, and it stays set until reset.
- Mid-operation reset: one unfilled load pending, then assert `resetN`=0 for one cycle. Queue empties and `exReady`=1; a subsequent `memValid` sets `memError` and produces no write.
